// File: rtl/pb_event_decoder.sv
// Push-button event decoder: synchronizer, debounce, and short/long/double-click detection.
// Define PB_AUTO_REPEAT_EN to add auto-repeat pulses while a long press is held.
module pb_event_decoder #(
  parameter int DB_CYC     = 50000,
  parameter int LONG_CYC   = 25000000,
  parameter int DBL_CYC    = 12500000,
  parameter int REPEAT_CYC = 5000000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  output logic held,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  // repeat is a reserved word, so the auto-repeat pulse carries a suffix
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_REL,
    WAIT_DBL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 2);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  // A lone press is reported a debounce period past the double-click window.
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DBL_CYC + DB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  if (DB_CYC < 2 || LONG_CYC < 1 || DBL_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("pb_event_decoder: illegal timing parameters");
  end

  logic sync1_q, sync2_q, pb_s_q;
  state_t state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [CNT_W-1:0] dur_inc;
  logic pending_q, pending_d;
  logic consumed_q, consumed_d;
  logic held_q, held_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;

`ifdef PB_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);
  logic long_done_q, long_done_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic rpt_q, rpt_d;
`endif

  assign dur_inc = (dur_cnt_q == CNT_MAX) ? dur_cnt_q : dur_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    pending_d  = pending_q;
    consumed_d = consumed_q;
    held_d     = held_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    dbl_d      = 1'b0;
`ifdef PB_AUTO_REPEAT_EN
    long_done_d = long_done_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_d       = 1'b0;
    // The repeat timer only runs in HELD, so release bounce merely pauses it.
    if (state_q == HELD && long_done_q) begin
      if (rpt_cnt_q >= RPT_LAST) begin
        rpt_d     = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (!pb_s_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end

      DB_PRESS: begin
        if (pb_s_q) begin
          if (pending_q && dur_cnt_q >= WIN_LAST) begin
            short_d   = 1'b1;
            pending_d = 1'b0;
            state_d   = IDLE;
          end else if (pending_q) begin
            state_d = WAIT_DBL;
          end else begin
            state_d = IDLE;
          end
        end else if (db_cnt_q >= DB_LAST) begin
          state_d   = HELD;
          held_d    = 1'b1;
          dur_cnt_d = '0;
          if (pending_q) begin
            dbl_d      = 1'b1;
            pending_d  = 1'b0;
            consumed_d = 1'b1;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        dur_cnt_d = dur_inc;
        if (!consumed_q && dur_cnt_q >= LONG_LAST) begin
          long_d     = 1'b1;
          consumed_d = 1'b1;
`ifdef PB_AUTO_REPEAT_EN
          long_done_d = 1'b1;
          rpt_cnt_d   = '0;
`endif
        end
        if (pb_s_q) begin
          state_d  = DB_REL;
          db_cnt_d = '0;
        end
      end

      DB_REL: begin
        dur_cnt_d = dur_inc;
        if (!pb_s_q) begin
          state_d = HELD;
        end else if (db_cnt_q >= DB_LAST) begin
          held_d = 1'b0;
`ifdef PB_AUTO_REPEAT_EN
          long_done_d = 1'b0;
`endif
          if (consumed_q) begin
            consumed_d = 1'b0;
            state_d    = IDLE;
          end else begin
            pending_d = 1'b1;
            dur_cnt_d = '0;
            state_d   = WAIT_DBL;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      WAIT_DBL: begin
        if (!pb_s_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end else if (dur_cnt_q >= WIN_LAST) begin
          short_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = IDLE;
        end else begin
          dur_cnt_d = dur_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      pb_s_q     <= 1'b1;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      dur_cnt_q  <= '0;
      pending_q  <= 1'b0;
      consumed_q <= 1'b0;
      held_q     <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      dbl_q      <= 1'b0;
    end else begin
      sync1_q    <= PB;
      sync2_q    <= sync1_q;
      pb_s_q     <= sync2_q;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      pending_q  <= pending_d;
      consumed_q <= consumed_d;
      held_q     <= held_d;
      short_q    <= short_d;
      long_q     <= long_d;
      dbl_q      <= dbl_d;
    end
  end

`ifdef PB_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      long_done_q <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_q       <= 1'b0;
    end else begin
      long_done_q <= long_done_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_q       <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign held         = held_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;

endmodule
